// File: rtl/ecc_apb_master_pkg.sv
// Shared definitions for the ECC APB master and the ECC_ENC_DEC slave:
// register offsets, CTRL / CODEWORD_WIDTH encodings and the sequencer states.
package ecc_apb_master_pkg;

   localparam logic [7:0] REG_CTRL           = 8'h00;
   localparam logic [7:0] REG_DATA_IN        = 8'h04;
   localparam logic [7:0] REG_CODEWORD_WIDTH = 8'h08;
   localparam logic [7:0] REG_NOISE          = 8'h0C;

   // Number of register writes per operation; CTRL goes last because writing it
   // starts the ECC operation.
   localparam int unsigned NUM_XFERS = 4;

   typedef enum logic [1:0] {
      MODE_ENCODE = 2'd0,
      MODE_DECODE = 2'd1,
      MODE_FULL   = 2'd2
   } ecc_mode_e;

   typedef enum logic [1:0] {
      CW_8  = 2'd0,
      CW_16 = 2'd1,
      CW_32 = 2'd2
   } ecc_width_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } apb_state_e;

   typedef enum logic [1:0] {
      XF_IDLE   = 2'd0,
      XF_SETUP  = 2'd1,
      XF_ACCESS = 2'd2
   } xfer_phase_e;

   // Register offset written by transfer index 0..3.
   function automatic logic [7:0] reg_offset(input logic [1:0] idx);
      logic [7:0] off;
      unique case (idx)
         2'd0:    off = REG_DATA_IN;
         2'd1:    off = REG_CODEWORD_WIDTH;
         2'd2:    off = REG_NOISE;
         default: off = REG_CTRL;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/ecc_apb_xfer.sv
// Two-phase APB write engine. A start pulse loads address/data; the engine then
// spends one SETUP and one ACCESS cycle on the bus. Without PREADY every ACCESS
// completes in a single cycle, and a start during ACCESS chains the next write
// with no idle cycle in between. PADDR/PWDATA keep their last value when idle.
module ecc_apb_xfer
   import ecc_apb_master_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata
);

   xfer_phase_e       phase_q, phase_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;

   // Phase sequencing and address/data capture on an accepted start.
   always_comb begin
      phase_d  = phase_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      unique case (phase_q)
         XF_IDLE:   if (start) phase_d = XF_SETUP;
         XF_SETUP:  phase_d = XF_ACCESS;
         XF_ACCESS: phase_d = start ? XF_SETUP : XF_IDLE;
         default:   phase_d = XF_IDLE;
      endcase
      if (start && (phase_q != XF_SETUP)) begin
         paddr_d  = addr;
         pwdata_d = data;
      end
   end

   // Engine registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= XF_IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
      end else begin
         phase_q  <= phase_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
      end
   end

   assign busy    = (phase_q != XF_IDLE);
   assign done    = (phase_q == XF_ACCESS);
   assign psel    = (phase_q != XF_IDLE);
   assign penable = (phase_q == XF_ACCESS);
   assign pwrite  = (phase_q != XF_IDLE);
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;

endmodule

// File: rtl/ecc_apb_master.sv
// ECC APB master: accepts one operation request, writes DATA_IN, CODEWORD_WIDTH,
// NOISE and CTRL to the ECC block over APB, then waits for operation_done or a
// timeout and reports the result with a one-cycle res_valid pulse.
//
// state  | meaning
// IDLE   | ready for a request (op_ready=1)
// SETUP  | APB setup phase of transfer idx_q
// ACCESS | APB access phase of transfer idx_q
// WAIT   | CTRL written, counting cycles until operation_done or timeout
// DONE   | res_valid pulse, result registers already updated
module ecc_apb_master
   import ecc_apb_master_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [1:0]                 op_mode,
   input  logic [1:0]                 op_width,
   input  logic [DATA_WIDTH-1:0]      op_data,
   input  logic [DATA_WIDTH-1:0]      op_noise,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       res_valid,
   output logic [DATA_WIDTH-1:0]      res_data,
   output logic [1:0]                 res_errors,
   output logic                       res_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   apb_state_e            state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   ecc_mode_e             mode_q, mode_d;
   ecc_width_e            width_q, width_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] noise_q, noise_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic [1:0]            res_errors_q, res_errors_d;
   logic                  res_timeout_q, res_timeout_d;

   logic                       xfer_start;
   logic [AMBA_ADDR_WIDTH-1:0] xfer_addr;
   logic [AMBA_WORD-1:0]       xfer_data;
   logic                       xfer_busy;
   logic                       xfer_done;
   logic [1:0]                 nxt_idx;
   logic [AMBA_WORD-1:0]       nxt_data;

   // Write data for the transfer following idx_q, zero-extended to the bus width.
   always_comb begin
      nxt_idx = idx_q + 2'd1;
      unique case (nxt_idx)
         2'd0:    nxt_data = AMBA_WORD'(data_q);
         2'd1:    nxt_data = AMBA_WORD'(width_q);
         2'd2:    nxt_data = AMBA_WORD'(noise_q);
         default: nxt_data = AMBA_WORD'(mode_q);
      endcase
   end

   // Sequencer: request acceptance, transfer chaining, wait/timeout, result capture.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      mode_d        = mode_q;
      width_d       = width_q;
      data_d        = data_q;
      noise_d       = noise_q;
      res_data_d    = res_data_q;
      res_errors_d  = res_errors_q;
      res_timeout_d = res_timeout_q;
      xfer_start    = 1'b0;
      xfer_addr     = '0;
      xfer_data     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               mode_d     = ecc_mode_e'(op_mode);
               width_d    = ecc_width_e'(op_width);
               data_d     = op_data;
               noise_d    = op_noise;
               idx_d      = 2'd0;
               xfer_start = 1'b1;
               xfer_addr  = AMBA_ADDR_WIDTH'(reg_offset(2'd0));
               xfer_data  = AMBA_WORD'(op_data);
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (xfer_done) begin
               if (idx_q == 2'(NUM_XFERS - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_WAIT;
               end else begin
                  idx_d      = nxt_idx;
                  xfer_start = 1'b1;
                  xfer_addr  = AMBA_ADDR_WIDTH'(reg_offset(nxt_idx));
                  xfer_data  = nxt_data;
                  state_d    = ST_SETUP;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // operation_done is checked first so it wins over a same-cycle timeout.
            if (operation_done) begin
               res_data_d    = data_out;
               res_errors_d  = num_of_errors;
               res_timeout_d = 1'b0;
               state_d       = ST_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               res_data_d    = '0;
               res_errors_d  = '0;
               res_timeout_d = 1'b1;
               state_d       = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         mode_q        <= MODE_ENCODE;
         width_q       <= CW_8;
         data_q        <= '0;
         noise_q       <= '0;
         res_data_q    <= '0;
         res_errors_q  <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         mode_q        <= mode_d;
         width_q       <= width_d;
         data_q        <= data_d;
         noise_q       <= noise_d;
         res_data_q    <= res_data_d;
         res_errors_q  <= res_errors_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   ecc_apb_xfer #(
      .ADDR_W (AMBA_ADDR_WIDTH),
      .DATA_W (AMBA_WORD)
   ) u_xfer (
      .clk     (clk),
      .rst     (rst),
      .start   (xfer_start),
      .addr    (xfer_addr),
      .data    (xfer_data),
      .busy    (xfer_busy),
      .done    (xfer_done),
      .psel    (PSEL),
      .penable (PENABLE),
      .pwrite  (PWRITE),
      .paddr   (PADDR),
      .pwdata  (PWDATA)
   );

   assign op_ready    = (state_q == ST_IDLE) && !xfer_busy;
   assign res_valid   = (state_q == ST_DONE);
   assign res_data    = res_data_q;
   assign res_errors  = res_errors_q;
   assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Bench for ecc_apb_master: directed scenarios plus randomized operations checked
// against a transaction-level model (expected write list and result timing).
module tb_ecc_apb_master;

   localparam int TMO = 10;
   localparam int LAT = 8;   // request cycle to CTRL access cycle

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_mode;
   logic [1:0]  op_width;
   logic [31:0] op_data;
   logic [31:0] op_noise;
   logic        PSEL, PENABLE, PWRITE;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic        operation_done;
   logic [31:0] data_out;
   logic [1:0]  num_of_errors;
   logic        res_valid;
   logic [31:0] res_data;
   logic [1:0]  res_errors;
   logic        res_timeout;

   int total = 0;
   int bad   = 0;

   ecc_apb_master #(
      .AMBA_WORD       (32),
      .AMBA_ADDR_WIDTH (20),
      .DATA_WIDTH      (32),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .op_valid       (op_valid),
      .op_ready       (op_ready),
      .op_mode        (op_mode),
      .op_width       (op_width),
      .op_data        (op_data),
      .op_noise       (op_noise),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .operation_done (operation_done),
      .data_out       (data_out),
      .num_of_errors  (num_of_errors),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .res_errors     (res_errors),
      .res_timeout    (res_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus monitor: collects completed writes and counts protocol violations.
   logic [51:0] wr_q[$];
   int          viol = 0;
   logic        prev_setup = 1'b0;
   logic [51:0] prev_aw = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_setup = 1'b0;
      end else begin
         if (PENABLE && !PSEL) viol++;
         if (PWRITE !== PSEL) viol++;
         if (PSEL && PENABLE) begin
            if (!prev_setup || prev_aw !== {PADDR, PWDATA}) viol++;
            wr_q.push_back({PADDR, PWDATA});
         end
         if (PSEL && !PENABLE && prev_setup) viol++;
         prev_setup = PSEL && !PENABLE;
         prev_aw    = {PADDR, PWDATA};
      end
   end

   // Reference model: what one operation should produce.
   logic [51:0] exp_wr[$];
   int          exp_delay;
   logic [31:0] exp_data;
   logic [1:0]  exp_err;
   logic        exp_to;

   function automatic void model(input logic [1:0] mode, input logic [1:0] width,
                                 input logic [31:0] data, input logic [31:0] noise,
                                 input logic [31:0] dout, input logic [1:0] errs,
                                 input int done_at);
      exp_wr.delete();
      exp_wr.push_back({20'h00004, data});
      exp_wr.push_back({20'h00008, 30'd0, width});
      exp_wr.push_back({20'h0000C, noise});
      exp_wr.push_back({20'h00000, 30'd0, mode});
      if (done_at >= 1 && done_at <= TMO) begin
         exp_delay = done_at;
         exp_data  = dout;
         exp_err   = errs;
         exp_to    = 1'b0;
      end else begin
         exp_delay = TMO;
         exp_data  = '0;
         exp_err   = '0;
         exp_to    = 1'b1;
      end
   endfunction

   // Observations from the last run_op.
   logic        obs_ready0;
   int          obs_ctrl_cycle;
   int          obs_res_cycle;
   int          obs_nvalid;
   int          obs_busy_ready;
   logic [31:0] obs_res_data;
   logic [1:0]  obs_res_err;
   logic        obs_res_to;
   logic [31:0] obs_res_end;

   // Drives one operation; done_at = WAIT cycle (1-based) carrying operation_done,
   // 0 = never. Returns extra cycles after the res_valid cycle.
   task automatic run_op(input logic [1:0] mode, input logic [1:0] width,
                         input logic [31:0] data, input logic [31:0] noise,
                         input logic [31:0] dout, input logic [1:0] errs,
                         input int done_at, input bit hold_valid, input bit spurious,
                         input int extra);
      int w;
      wr_q.delete();
      obs_ctrl_cycle = -1;
      obs_res_cycle  = -1;
      obs_nvalid     = 0;
      obs_busy_ready = 0;
      obs_res_data   = 'x;
      obs_res_err    = 'x;
      obs_res_to     = 1'bx;
      @(negedge clk);
      obs_ready0 = op_ready;
      op_mode    = mode;
      op_width   = width;
      op_data    = data;
      op_noise   = noise;
      op_valid   = 1'b1;
      w = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (obs_res_cycle < 0 && op_ready) obs_busy_ready++;
         if (PSEL && PENABLE && PADDR == 20'h0 && obs_ctrl_cycle < 0) obs_ctrl_cycle = c;
         if (res_valid) begin
            obs_nvalid++;
            if (obs_res_cycle < 0) begin
               obs_res_cycle = c;
               obs_res_data  = res_data;
               obs_res_err   = res_errors;
               obs_res_to    = res_timeout;
            end
         end
         if (!hold_valid || obs_ctrl_cycle >= 0) op_valid = 1'b0;
         operation_done = 1'b0;
         data_out       = $urandom;
         num_of_errors  = 2'($urandom_range(0, 3));
         if (spurious && c == 3) operation_done = 1'b1;
         if (obs_ctrl_cycle >= 0 && obs_res_cycle < 0) begin
            w = c - obs_ctrl_cycle;
            if (done_at > 0 && w == done_at) begin
               operation_done = 1'b1;
               data_out       = dout;
               num_of_errors  = errs;
            end
         end
         obs_res_end = res_data;
         if (obs_res_cycle >= 0 && c >= obs_res_cycle + extra) break;
      end
      op_valid       = 1'b0;
      operation_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_op_ready got=%0b exp=1", op_ready); end
      total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++; $display("FAIL rst_apb_ctl got=%b exp=000", {PSEL, PENABLE, PWRITE}); end
      total++; if ({PADDR, PWDATA} !== 52'd0) begin bad++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", PADDR, PWDATA); end
      total++; if ({res_valid, res_data, res_errors, res_timeout} !== 36'd0) begin bad++; $display("FAIL rst_res got=%b/%h/%0d/%b exp=0", res_valid, res_data, res_errors, res_timeout); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_encode();
      model(2'd0, 2'd0, 32'hA5, 32'h0, 32'h1A5, 2'd0, 3);
      run_op(2'd0, 2'd0, 32'hA5, 32'h0, 32'h1A5, 2'd0, 3, 1'b0, 1'b0, 3);
      total++; if (obs_ready0 !== 1'b1) begin bad++; $display("FAIL enc_ready got=%0b exp=1", obs_ready0); end
      total++; if (wr_q.size() != 4) begin bad++; $display("FAIL enc_nwrites got=%0d exp=4", wr_q.size()); end
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL enc_write%0d got=%h exp=%h", i, wr_q[i], exp_wr[i]); end
      end
      total++; if (obs_ctrl_cycle != LAT) begin bad++; $display("FAIL enc_latency got=%0d exp=%0d", obs_ctrl_cycle, LAT); end
      total++; if (obs_res_cycle != LAT + 1 + exp_delay) begin bad++; $display("FAIL enc_res_cycle got=%0d exp=%0d", obs_res_cycle, LAT + 1 + exp_delay); end
      total++; if (obs_res_data !== 32'h1A5 || obs_res_to !== 1'b0) begin bad++; $display("FAIL enc_result got=%h/%b exp=1a5/0", obs_res_data, obs_res_to); end
      total++; if (obs_nvalid != 1) begin bad++; $display("FAIL enc_pulses got=%0d exp=1", obs_nvalid); end
      total++; if (obs_busy_ready != 0) begin bad++; $display("FAIL enc_ready_busy got=%0d exp=0", obs_busy_ready); end
      total++; if (obs_res_end !== 32'h1A5) begin bad++; $display("FAIL enc_res_hold got=%h exp=1a5", obs_res_end); end
      total++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b000, 20'h0, 32'h0}) begin bad++; $display("FAIL enc_idle_hold got=%b/%h/%h exp=000/0/0", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA); end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      d = $urandom;
      model(2'd1, 2'd2, d, 32'h0000_0100, d, 2'd1, 5);
      run_op(2'd1, 2'd2, d, 32'h0000_0100, d, 2'd1, 5, 1'b0, 1'b0, 4);
      total++; if (obs_res_err !== 2'd1) begin bad++; $display("FAIL dec_errors got=%0d exp=1", obs_res_err); end
      total++; if (obs_res_data !== d || obs_res_to !== 1'b0) begin bad++; $display("FAIL dec_result got=%h/%b exp=%h/0", obs_res_data, obs_res_to, d); end
      total++; if (obs_nvalid != 1) begin bad++; $display("FAIL dec_pulses got=%0d exp=1", obs_nvalid); end
      total++; if (wr_q.size() != 4 || wr_q[3] !== exp_wr[3] || wr_q[2] !== exp_wr[2]) begin bad++; $display("FAIL dec_writes got_n=%0d exp_n=4", wr_q.size()); end
      total++; if ({PADDR, PWDATA} !== {20'h0, 32'd1}) begin bad++; $display("FAIL dec_idle_hold got=%h/%h exp=0/1", PADDR, PWDATA); end
   endtask

   task automatic test_timeout();
      model(2'd2, 2'd1, 32'h1234_5678, 32'h8, 32'hDEAD, 2'd2, 0);
      run_op(2'd2, 2'd1, 32'h1234_5678, 32'h8, 32'hDEAD, 2'd2, 0, 1'b0, 1'b0, 3);
      total++; if (obs_res_cycle != LAT + 1 + TMO) begin bad++; $display("FAIL tmo_cycle got=%0d exp=%0d", obs_res_cycle, LAT + 1 + TMO); end
      total++; if (obs_res_to !== 1'b1 || obs_res_data !== 32'h0 || obs_res_err !== 2'd0) begin bad++; $display("FAIL tmo_result got=%b/%h/%0d exp=1/0/0", obs_res_to, obs_res_data, obs_res_err); end
      total++; if (obs_nvalid != 1) begin bad++; $display("FAIL tmo_pulses got=%0d exp=1", obs_nvalid); end
      // operation_done on the last allowed cycle beats the timeout
      model(2'd0, 2'd0, 32'h5A, 32'h0, 32'h77, 2'd0, TMO);
      run_op(2'd0, 2'd0, 32'h5A, 32'h0, 32'h77, 2'd0, TMO, 1'b0, 1'b0, 1);
      total++; if (obs_res_to !== 1'b0 || obs_res_data !== 32'h77 || obs_res_cycle != LAT + 1 + TMO) begin bad++; $display("FAIL tmo_tie got=%b/%h/%0d exp=0/77/%0d", obs_res_to, obs_res_data, obs_res_cycle, LAT + 1 + TMO); end
      // one cycle too late: timeout already taken
      model(2'd0, 2'd0, 32'h5A, 32'h0, 32'h77, 2'd3, TMO + 1);
      run_op(2'd0, 2'd0, 32'h5A, 32'h0, 32'h77, 2'd3, TMO + 1, 1'b0, 1'b0, 3);
      total++; if (obs_res_to !== exp_to || obs_res_data !== exp_data || obs_nvalid != 1) begin bad++; $display("FAIL tmo_late got=%b/%h/%0d exp=%b/%h/1", obs_res_to, obs_res_data, obs_nvalid, exp_to, exp_data); end
   endtask

   task automatic test_spurious();
      logic [31:0] d, n;
      d = $urandom;
      n = $urandom;
      model(2'd2, 2'd2, d, n, 32'hCAFE, 2'd2, 4);
      run_op(2'd2, 2'd2, d, n, 32'hCAFE, 2'd2, 4, 1'b1, 1'b1, 3);
      total++; if (wr_q.size() != 4) begin bad++; $display("FAIL spur_nwrites got=%0d exp=4", wr_q.size()); end
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL spur_write%0d got=%h exp=%h", i, wr_q[i], exp_wr[i]); end
      end
      total++; if (obs_ctrl_cycle != LAT) begin bad++; $display("FAIL spur_latency got=%0d exp=%0d", obs_ctrl_cycle, LAT); end
      total++; if (obs_res_cycle != LAT + 1 + exp_delay || obs_res_data !== exp_data || obs_res_err !== exp_err) begin bad++; $display("FAIL spur_result got=%0d/%h/%0d exp=%0d/%h/%0d", obs_res_cycle, obs_res_data, obs_res_err, LAT + 1 + exp_delay, exp_data, exp_err); end
      total++; if (obs_nvalid != 1 || obs_busy_ready != 0) begin bad++; $display("FAIL spur_pulses got=%0d/%0d exp=1/0", obs_nvalid, obs_busy_ready); end
   endtask

   task automatic test_reset_mid();
      int seen_valid;
      int seen_psel;
      @(negedge clk);
      op_mode = 2'd1; op_width = 2'd1; op_data = 32'h0F0F_0F0F; op_noise = 32'h3; op_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         op_valid = 1'b0;
      end
      total++; if (!(PSEL && PENABLE && PADDR == 20'h0000C)) begin bad++; $display("FAIL rmid_pre got=%b%b/%h exp=11/0000c", PSEL, PENABLE, PADDR); end
      #2 rst = 1'b1;
      #1;
      total++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 55'd0) begin bad++; $display("FAIL rmid_apb got=%b/%h/%h exp=000/0/0", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA); end
      total++; if (res_valid !== 1'b0 || res_data !== 32'h0 || op_ready !== 1'b1) begin bad++; $display("FAIL rmid_res got=%b/%h/%b exp=0/0/1", res_valid, res_data, op_ready); end
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 0;
      seen_psel  = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (res_valid) seen_valid++;
         if (PSEL) seen_psel++;
      end
      total++; if (seen_valid != 0 || seen_psel != 0) begin bad++; $display("FAIL rmid_abort got=%0d/%0d exp=0/0", seen_valid, seen_psel); end
      model(2'd0, 2'd1, 32'h3C, 32'h1, 32'h99, 2'd0, 2);
      run_op(2'd0, 2'd1, 32'h3C, 32'h1, 32'h99, 2'd0, 2, 1'b0, 1'b0, 1);
      total++; if (wr_q.size() != 4 || wr_q[0] !== exp_wr[0] || wr_q[3] !== exp_wr[3]) begin bad++; $display("FAIL rmid_restart got_n=%0d first=%h exp=%h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 52'h0, exp_wr[0]); end
      total++; if (obs_ctrl_cycle != LAT || obs_res_data !== 32'h99) begin bad++; $display("FAIL rmid_result got=%0d/%h exp=%0d/99", obs_ctrl_cycle, obs_res_data, LAT); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  m, wd;
      logic [31:0] d, n, o;
      for (int k = 0; k < 3; k++) begin
         m = 2'($urandom_range(0, 2)); wd = 2'($urandom_range(0, 2));
         d = $urandom; n = $urandom; o = $urandom;
         model(m, wd, d, n, o, 2'd0, 1);
         run_op(m, wd, d, n, o, 2'd0, 1, 1'b0, 1'b0, 0);
         total++; if (obs_ready0 !== 1'b1 || obs_ctrl_cycle != LAT) begin bad++; $display("FAIL b2b%0d_start got=%b/%0d exp=1/%0d", k, obs_ready0, obs_ctrl_cycle, LAT); end
         total++; if (wr_q.size() != 4 || wr_q[1] !== exp_wr[1] || wr_q[3] !== exp_wr[3]) begin bad++; $display("FAIL b2b%0d_writes got_n=%0d exp_n=4", k, wr_q.size()); end
         total++; if (obs_res_data !== o || obs_res_cycle != LAT + 2) begin bad++; $display("FAIL b2b%0d_result got=%h/%0d exp=%h/%0d", k, obs_res_data, obs_res_cycle, o, LAT + 2); end
      end
   endtask

   task automatic test_random();
      logic [1:0]  m, wd, e;
      logic [31:0] d, n, o;
      int          da;
      for (int k = 0; k < 20; k++) begin
         m = 2'($urandom_range(0, 2)); wd = 2'($urandom_range(0, 2)); e = 2'($urandom_range(0, 3));
         d = $urandom; n = $urandom; o = $urandom;
         da = $urandom_range(0, TMO + 3);
         model(m, wd, d, n, o, e, da);
         run_op(m, wd, d, n, o, e, da, 1'b0, 1'b0, $urandom_range(0, 2));
         total++; if (wr_q.size() != 4) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d exp=4", k, wr_q.size()); end
         for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rnd%0d_write%0d got=%h exp=%h", k, i, wr_q[i], exp_wr[i]); end
         end
         total++; if (obs_res_cycle != LAT + 1 + exp_delay) begin bad++; $display("FAIL rnd%0d_res_cycle got=%0d exp=%0d", k, obs_res_cycle, LAT + 1 + exp_delay); end
         total++; if ({obs_res_data, obs_res_err, obs_res_to} !== {exp_data, exp_err, exp_to}) begin bad++; $display("FAIL rnd%0d_result got=%h/%0d/%b exp=%h/%0d/%b", k, obs_res_data, obs_res_err, obs_res_to, exp_data, exp_err, exp_to); end
         total++; if (obs_nvalid != 1 || obs_busy_ready != 0) begin bad++; $display("FAIL rnd%0d_pulses got=%0d/%0d exp=1/0", k, obs_nvalid, obs_busy_ready); end
      end
   endtask

   task automatic test_protocol();
      total++; if (viol != 0) begin bad++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
   endtask

   initial begin
      op_valid = 1'b0; op_mode = '0; op_width = '0; op_data = '0; op_noise = '0;
      operation_done = 1'b0; data_out = '0; num_of_errors = '0;
      test_reset();
      test_encode();
      test_decode();
      test_timeout();
      test_spurious();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ecc_apb_master.md
ECC_APB_MASTER -- requirements
Module: ecc_apb_master

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-002 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, ECC payload width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for operation_done.
REQ-005 SHALL have ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op_valid  input  1  operation request.
- op_ready  output  1  request accepted when op_valid & op_ready.
- op_mode  input  2  CTRL value: 0 encode, 1 decode, 2 full.
- op_width  input  2  CODEWORD_WIDTH value: 0 = 8, 1 = 16, 2 = 32 bits.
- op_data  input  DATA_WIDTH  DATA_IN value.
- op_noise  input  DATA_WIDTH  NOISE value.
- PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
- PADDR  output  AMBA_ADDR_WIDTH  APB address.
- PWDATA  output  AMBA_WORD  APB write data, zero-extended from field width.
- operation_done  input  1  completion pulse from ECC block.
- data_out  input  DATA_WIDTH  ECC result.
- num_of_errors  input  2  ECC error count.
- res_valid  output  1  one-cycle result pulse.
- res_data  output  DATA_WIDTH  captured data_out.
- res_errors  output  2  captured num_of_errors.
- res_timeout  output  1  qualifies res_valid: 1 = timed out.

Function
REQ-006 SHALL implement FSM IDLE, SETUP, ACCESS, WAIT, DONE.
REQ-007 op_ready SHALL be 1 only in IDLE; on acceptance op_mode, op_width, op_data, op_noise SHALL be latched and the FSM SHALL go to SETUP with transfer index 0.
REQ-008 Transfers SHALL be issued in order: index 0 DATA_IN @0x04, 1 CODEWORD_WIDTH @0x08, 2 NOISE @0x0C, 3 CTRL @0x00 (CTRL last, it triggers the operation).
REQ-009 SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid; next cycle ACCESS.
REQ-010 ACCESS: PSEL=1, PENABLE=1, PADDR/PWDATA/PWRITE unchanged from SETUP; there is no PREADY, so each transfer SHALL complete in exactly one ACCESS cycle.
REQ-011 After ACCESS with index < 3, the FSM SHALL return to SETUP with index+1; after index 3 it SHALL go to WAIT with the timeout counter cleared.
REQ-012 Outside SETUP and ACCESS: PSEL=0, PENABLE=0, PWRITE=0; PADDR and PWDATA hold their last value.
REQ-013 Request-to-CTRL-ACCESS latency SHALL be 8 cycles (4 transfers x 2), with no idle cycles between transfers.
REQ-014 In WAIT the counter SHALL increment each cycle.
- operation_done=1: capture data_out and num_of_errors, clear res_timeout, go to DONE.
- Counter reaching TIMEOUT_CYCLES with no operation_done: res_data=0, res_errors=0, res_timeout=1, go to DONE.
- operation_done and timeout in the same cycle: operation_done wins.
REQ-015 operation_done asserted outside WAIT SHALL be ignored.
REQ-016 DONE SHALL assert res_valid for exactly one cycle, then go to IDLE. res_data, res_errors and res_timeout SHALL hold until the next capture.
REQ-017 op_valid asserted outside IDLE SHALL NOT be accepted; back-to-back operations are spaced by at least one IDLE cycle.

Reset
REQ-018 On rst=1, asynchronously: FSM=IDLE, op_ready=1, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, res_valid=0, res_data=0, res_errors=0, res_timeout=0, counter and index cleared.
REQ-019 Reset mid-transfer or mid-WAIT SHALL abort the operation with no res_valid; the first operation after reset SHALL start from index 0.

Structure
REQ-020 Register offsets, op_mode and op_width encodings, and the FSM state enum SHALL live in a shared package, which the ECC_ENC_DEC slave also uses.
REQ-021 A sub-module ecc_apb_xfer SHALL implement the 2-phase APB write engine (start, addr, data -> busy, done); the sequencer and timeout logic stay in ecc_apb_master.

Verification
REQ-022 Encode: op_mode=0, op_width=0, op_data=0xA5, op_noise=0, operation_done after 3 WAIT cycles with data_out=0x1A5 -> APB writes 0x04=0xA5, 0x08=0, 0x0C=0, 0x00=0 in that order; res_valid=1, res_data=0x1A5, res_timeout=0.
REQ-023 Decode with one flipped bit: op_mode=1, num_of_errors=1 at operation_done -> res_errors=1, exactly one res_valid pulse.
REQ-024 Timeout: TIMEOUT_CYCLES=10, operation_done never asserted -> res_valid 10 cycles after WAIT entry, res_timeout=1, res_data=0.
REQ-025 Spurious and late inputs: operation_done pulsed during a SETUP phase and op_valid held during ACCESS -> both ignored; the APB sequence is unchanged.
REQ-026 Reset asserted during ACCESS of index 2 -> APB outputs go to 0 immediately, no res_valid; the next request restarts at PADDR=0x04.
REQ-027 Protocol check: every ACCESS is preceded by SETUP with identical PADDR/PWDATA, and PENABLE is never 1 while PSEL is 0.
